// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: sequencer states and byte width.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    WAIT,
    GAP
  } state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Ports: req (request vector), ptr (search start), grant (chosen index),
//        any_req (at least one request set).
module spi_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;

  // Walk the ring starting at ptr; the first hit wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((32'(ptr) + k) % N_REQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master between N_REQ byte-stream requesters: round-robin
// grant per burst, one load per byte, response routing, inter-burst CS gap
// and per-byte timeout.
// Ports: CLK_M/reset (sync, active-high); req/req_data/req_last/req_ready
//        (requester side); rsp_valid/rsp_data/err (per-requester results);
//        busy/owner (status); m_transmit/m_d_valid/m_data/m_done/m_rx
//        (SPI master side).
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        CLK_M,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [SPI_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [SPI_BYTE_W-1:0]       rsp_data,
  output logic [N_REQ-1:0]            err,
  output logic                        busy,
  output logic [IDX_W-1:0]            owner,
  output logic                        m_transmit,
  output logic                        m_d_valid,
  output logic [SPI_BYTE_W-1:0]       m_data,
  input  logic                        m_done,
  input  logic [SPI_BYTE_W-1:0]       m_rx
);

  localparam int unsigned TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic              last_q;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]  grant;
  logic              any_req;
  logic [IDX_W-1:0]  next_ptr;
  logic              to_hit;
  logic [SPI_BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*SPI_BYTE_W +: SPI_BYTE_W];
  end

  spi_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign next_ptr = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT - 1));

  // Sequencer: grant, per-byte load/wait, then CS gap. Every burst end
  // advances the round-robin pointer past the owner.
  always_ff @(posedge CLK_M) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      last_q  <= 1'b0;
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant;
            state <= SETUP;
          end
        end
        SETUP: state <= LOAD;
        LOAD: begin
          if (req[owner]) begin
            last_q <= req_last[owner];
            to_cnt <= '0;
            state  <= WAIT;
          end else begin
            ptr     <= next_ptr;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        WAIT: begin
          // A done on the final timeout cycle still counts as completion.
          if (m_done) begin
            if (last_q) begin
              ptr     <= next_ptr;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= LOAD;
            end
          end else if (to_hit) begin
            ptr     <= next_ptr;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the state register. Strobes are suppressed while
  // reset is asserted so an aborted burst reports nothing.
  always_comb begin
    m_transmit = 1'b0;
    m_d_valid  = 1'b0;
    m_data     = '0;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_data   = '0;
    err        = '0;
    busy       = (state != IDLE);
    case (state)
      SETUP: m_transmit = 1'b1;
      LOAD: begin
        m_transmit = 1'b1;
        if (req[owner] && !reset) begin
          m_d_valid        = 1'b1;
          m_data           = req_bytes[owner];
          req_ready[owner] = 1'b1;
        end
      end
      WAIT: begin
        m_transmit = 1'b1;
        if (!reset) begin
          if (m_done) begin
            rsp_valid[owner] = 1'b1;
            rsp_data         = m_rx;
          end else if (to_hit) begin
            err[owner] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: transaction-level model of
// requesters, SPI master and round-robin order, with random data and delays.
module tb_spi_master_arbiter;

  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_last, req_ready, rsp_valid, err;
  logic [8*N-1:0] req_data;
  logic [7:0]     rsp_data, m_data, m_rx;
  logic           busy, m_transmit, m_d_valid, m_done;
  logic [1:0]     owner;

  always #5 clk = ~clk;

  spi_master_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .CLK_M(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .err(err), .busy(busy), .owner(owner),
    .m_transmit(m_transmit), .m_d_valid(m_d_valid), .m_data(m_data),
    .m_done(m_done), .m_rx(m_rx)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [7:0] q [N][$];
  int  refill [N];
  bit  no_last [N];
  int  ptr, cur, exp_load, exp_fall, exp_idle, load_cyc, done_at;
  bit  awaiting, last_byte, in_burst, prev_tx, prev_busy, spurious, rst_now;
  logic [N-1:0] prev_req;
  int  rx_mode, delay_mode;
  logic [7:0] rx_val;
  int  grants[$];
  logic [7:0] rsp_log[$];
  int  rise_cyc, fall_cnt, switch_at, n_ready, n_rsp, n_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0 || refill[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: drive requesters/master, then observe and check.
  task automatic step();
    bit done_now, to_now, ld_exp;
    logic dn;
    @(negedge clk);
    cyc++;
    reset = rst_now;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() == 0 && refill[i] > 0) begin
        q[i].push_back(8'($urandom));
        refill[i]--;
      end
      req[i] = (q[i].size() != 0);
      req_data[8*i +: 8] = 8'($urandom);
      if (req[i]) req_data[8*i +: 8] = q[i][0];
      req_last[i] = (q[i].size() == 1) && !no_last[i];
    end
    dn = awaiting && (done_at == cyc);
    if (!awaiting && spurious && ($urandom_range(7) == 0)) dn = 1'b1;
    if (rst_now) dn = 1'b1;
    m_done = dn;
    m_rx = (dn && awaiting) ? rx_val : 8'($urandom);
    #1;
    if (rst_now) begin
      check("rst_rsp", 32'(rsp_valid), 0);
      check("rst_err", 32'(err), 0);
      ptr = 0; awaiting = 0; in_burst = 0;
      prev_tx = 0; prev_busy = 0; prev_req = '0;
      for (int i = 0; i < N; i++) begin q[i].delete(); refill[i] = 0; end
      return;
    end
    if (m_transmit && !prev_tx) begin
      check("rise_from_idle", 32'(prev_busy), 0);
      cur = rr_pick(prev_req, ptr);
      check("owner", 32'(owner), 32'(cur));
      if (cur < 0) cur = 0;
      grants.push_back(cur);
      rise_cyc = cyc; exp_load = cyc + 1; exp_fall = -1; exp_idle = -1; in_burst = 1;
    end
    done_now = awaiting && m_done;
    to_now   = awaiting && !m_done && (cyc == load_cyc + TO);
    if (rsp_valid != 0 || done_now) begin
      check("rsp_valid", 32'(rsp_valid), done_now ? (32'(1) << cur) : 0);
      if (done_now) begin
        check("rsp_data", 32'(rsp_data), 32'(m_rx));
        rsp_log.push_back(rsp_data);
        n_rsp++;
      end
    end
    if (err != 0 || to_now) check("err", 32'(err), to_now ? (32'(1) << cur) : 0);
    if (done_now) begin
      awaiting = 0;
      if (last_byte) exp_fall = cyc + 1; else exp_load = cyc + 1;
    end else if (to_now) begin
      awaiting = 0; exp_fall = cyc + 1; n_to++;
    end
    ld_exp = in_burst && !awaiting && cyc == exp_load && q[cur].size() != 0;
    if (m_d_valid || req_ready != 0 || ld_exp) begin
      check("load_dv", 32'(m_d_valid), 32'(ld_exp));
      check("load_ready", 32'(req_ready), ld_exp ? (32'(1) << cur) : 0);
      if (ld_exp) begin
        check("load_data", 32'(m_data), 32'(q[cur][0]));
        last_byte = (q[cur].size() == 1) && !no_last[cur];
        rx_val = (rx_mode == 1) ? q[cur][0] : (rx_mode == 2) ? 8'hCA : 8'($urandom);
        void'(q[cur].pop_front());
        awaiting = 1; load_cyc = cyc; n_ready++;
        done_at = (delay_mode == 1) ? -1 : (delay_mode == 2) ? cyc + TO : cyc + int'($urandom_range(12, 1));
      end
    end else if (in_burst && !awaiting && cyc == exp_load) begin
      exp_fall = cyc + 1;
    end
    if (!m_transmit && prev_tx) begin
      check("tx_fall", 32'(cyc), 32'(exp_fall));
      ptr = (cur + 1) % N; exp_idle = cyc + GAP; in_burst = 0; fall_cnt++;
      if (fall_cnt == switch_at) for (int i = 0; i < N; i++) q[i].push_back(8'($urandom));
    end
    if (!busy && prev_busy) check("gap_len", 32'(cyc), 32'(exp_idle));
    prev_tx = m_transmit; prev_busy = busy; prev_req = req;
  endtask

  task automatic run(input int maxc);
    int k = 0;
    do begin
      step(); k++;
    end while (k < maxc && !(all_empty() && !busy && !awaiting && !in_burst));
    check("drained", 32'(busy || awaiting || !all_empty()), 0);
  endtask

  task automatic do_reset();
    rst_now = 1; step(); step();
    rst_now = 0; step();
    fall_cnt = 0; grants.delete(); rsp_log.delete();
    n_ready = 0; n_rsp = 0; n_to = 0;
  endtask

  task automatic clr_counts();
    grants.delete(); rsp_log.delete(); n_ready = 0; n_rsp = 0; n_to = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, exp_order[8];
    exp_order = '{0, 2, 0, 2, 3, 0, 1, 2};
    req = '0; req_last = '0; req_data = '0; m_done = 0; m_rx = '0; reset = 1;
    for (int i = 0; i < N; i++) begin refill[i] = 0; no_last[i] = 0; end
    ptr = 0; cur = 0; awaiting = 0; in_burst = 0; prev_tx = 0; prev_busy = 0;
    prev_req = '0; spurious = 0; rx_mode = 0; delay_mode = 0; switch_at = -1;
    exp_load = -1; exp_fall = -1; exp_idle = -1; load_cyc = -1000; done_at = -1;

    do_reset();
    check("rst_outs", {26'd0, m_transmit, busy, owner, m_d_valid, 1'b0}, 0);
    check("rst_strobes", {20'd0, req_ready, rsp_valid, err}, 0);

    // Single byte with fixed master reply.
    rx_mode = 2;
    q[0].push_back(8'hB3);
    t = cyc + 1;
    run(300);
    check("t1_rise_lat", 32'(rise_cyc), 32'(t + 1));
    check("t1_rsp_cnt", 32'(rsp_log.size()), 1);
    if (rsp_log.size() > 0) check("t1_rsp_data", 32'(rsp_log[0]), 32'hCA);

    // Fairness: 0101 held, then 1111.
    do_reset();
    rx_mode = 0;
    q[0].push_back(8'($urandom)); q[2].push_back(8'($urandom));
    refill[0] = 1; refill[2] = 1; switch_at = 4;
    run(3000);
    switch_at = -1;
    check("fair_cnt", 32'(grants.size()), 8);
    for (int i = 0; i < 8; i++)
      if (i < grants.size()) check("fair_order", 32'(grants[i]), 32'(exp_order[i]));

    // Three-byte burst, master echoes.
    clr_counts(); rx_mode = 1;
    q[1].push_back(8'h11); q[1].push_back(8'h22); q[1].push_back(8'h33);
    run(300);
    check("burst_ready", 32'(n_ready), 3);
    check("burst_rsp", 32'(n_rsp), 3);
    if (rsp_log.size() == 3) begin
      check("burst_b0", 32'(rsp_log[0]), 32'h11);
      check("burst_b1", 32'(rsp_log[1]), 32'h22);
      check("burst_b2", 32'(rsp_log[2]), 32'h33);
    end

    // Timeout: master never answers.
    clr_counts(); rx_mode = 0; delay_mode = 1;
    q[2].push_back(8'($urandom));
    run(300);
    check("to_err_cnt", 32'(n_to), 1);
    check("to_rsp_cnt", 32'(n_rsp), 0);

    // Done on the final timeout cycle.
    clr_counts(); delay_mode = 2;
    q[$urandom_range(N-1)].push_back(8'($urandom));
    run(300);
    check("coin_rsp", 32'(n_rsp), 1);
    check("coin_err", 32'(n_to), 0);

    // Requester withdraws without ever flagging last.
    clr_counts(); delay_mode = 0; no_last[3] = 1;
    q[3].push_back(8'($urandom)); q[3].push_back(8'($urandom));
    run(300);
    no_last[3] = 0;
    check("wd_rsp", 32'(n_rsp), 2);
    check("wd_grants", 32'(grants.size()), 1);

    // Random traffic with stray done pulses outside the wait window.
    clr_counts(); spurious = 1; rx_mode = 0;
    for (int r = 0; r < 25; r++) begin
      delay_mode = ($urandom_range(9) == 0) ? 1 : ($urandom_range(9) == 0) ? 2 : 0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(1) == 1)
          for (int b = 0; b < int'($urandom_range(4, 1)); b++) q[i].push_back(8'($urandom));
      run(3000);
    end
    spurious = 0; delay_mode = 0;

    // Reset in the middle of a burst.
    do_reset();
    delay_mode = 1;
    q[2].push_back(8'h01); q[2].push_back(8'h02); q[2].push_back(8'h03);
    for (int k = 0; k < 200 && !(awaiting && cyc == load_cyc + 3); k++) step();
    check("rmid_reached", 32'(awaiting), 1);
    check("rmid_owner_pre", 32'(owner), 2);
    rst_now = 1; step(); rst_now = 0;
    step();
    check("rmid_tx", 32'(m_transmit), 0);
    check("rmid_busy", 32'(busy), 0);
    check("rmid_owner", 32'(owner), 0);
    check("rmid_strobes", {20'd0, req_ready, rsp_valid, err}, 0);
    clr_counts(); delay_mode = 0;
    q[3].push_back(8'($urandom));
    run(300);
    check("rmid_regrant_cnt", 32'(grants.size()), 1);
    if (grants.size() > 0) check("rmid_regrant", 32'(grants[0]), 3);
    check("rmid_rsp", 32'(n_rsp), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
